hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32 core.
- Drives per-stage enable and flush for PC, fetch/decode, decode/execute, execute/memory and memory/writeback registers.
- Resolves load-use stalls, EX-stage branch/jump redirects and data-memory wait states; generates EX operand forwarding selects.
- Keeps saturating stall/flush counters and a sticky memory-timeout flag for debug.

---
 rtl/hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core: stage enables/flushes,
// load-use and memory-wait stalls, EX redirects, operand forwarding and debug counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [4:0]       fd_rs1_i,
    input  logic [4:0]       fd_rs2_i,
    input  logic             fd_uses_rs1_i,
    input  logic             fd_uses_rs2_i,
    input  logic [4:0]       de_rs1_i,
    input  logic [4:0]       de_rs2_i,
    input  logic [4:0]       de_rd_i,
    input  logic             de_mem_read_i,
    input  logic [4:0]       em_rd_i,
    input  logic             em_reg_write_i,
    input  logic [4:0]       mw_rd_i,
    input  logic             mw_reg_write_i,
    input  logic             e_pc_select_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_en_o,
    output logic             fd_en_o,
    output logic             de_en_o,
    output logic             em_en_o,
    output logic             mw_en_o,
    output logic             fd_flush_o,
    output logic             de_flush_o,
    output logic             mw_flush_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_timeout_o
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_REDIRECT   = 2'd3
    } state_t;

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [WW-1:0]    r_wait_cnt;
    logic             r_mem_timeout;

    logic w_mem_stall;
    logic w_redirect;
    logic w_load_use;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_mem_stall = dmem_req_i & ~dmem_ready_i;
    // A redirect seen during a memory wait stays pending in the frozen EX stage.
    assign w_redirect  = e_pc_select_i & ~w_mem_stall;
    assign w_rs1_hit   = fd_uses_rs1_i & (fd_rs1_i == de_rd_i);
    assign w_rs2_hit   = fd_uses_rs2_i & (fd_rs2_i == de_rd_i);
    assign w_load_use  = de_mem_read_i & (de_rd_i != 5'd0) & (w_rs1_hit | w_rs2_hit)
                       & ~w_mem_stall & ~e_pc_select_i;

    always_comb begin
        w_next_state = ST_RUN;
        pc_en_o      = 1'b1;
        fd_en_o      = 1'b1;
        de_en_o      = 1'b1;
        em_en_o      = 1'b1;
        mw_en_o      = 1'b1;
        fd_flush_o   = 1'b0;
        de_flush_o   = 1'b0;
        mw_flush_o   = 1'b0;
        if (w_mem_stall) begin
            w_next_state = ST_MEM_WAIT;
            pc_en_o      = 1'b0;
            fd_en_o      = 1'b0;
            de_en_o      = 1'b0;
            em_en_o      = 1'b0;
            mw_flush_o   = 1'b1;
        end else if (w_redirect) begin
            w_next_state = ST_REDIRECT;
            fd_flush_o   = 1'b1;
            de_flush_o   = 1'b1;
        end else if (w_load_use) begin
            w_next_state = ST_LOAD_STALL;
            pc_en_o      = 1'b0;
            fd_en_o      = 1'b0;
            de_flush_o   = 1'b1;
        end
        // Hold every stage and keep bubbles loading while reset is asserted.
        if (reset_i) begin
            pc_en_o    = 1'b0;
            fd_en_o    = 1'b0;
            de_en_o    = 1'b0;
            em_en_o    = 1'b0;
            mw_en_o    = 1'b0;
            fd_flush_o = 1'b1;
            de_flush_o = 1'b1;
            mw_flush_o = 1'b1;
        end
    end

    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (em_reg_write_i && em_rd_i != 5'd0 && em_rd_i == de_rs1_i) begin
            fwd_a_o = 2'b10;
        end else if (mw_reg_write_i && mw_rd_i != 5'd0 && mw_rd_i == de_rs1_i) begin
            fwd_a_o = 2'b01;
        end
        if (em_reg_write_i && em_rd_i != 5'd0 && em_rd_i == de_rs2_i) begin
            fwd_b_o = 2'b10;
        end else if (mw_reg_write_i && mw_rd_i != 5'd0 && mw_rd_i == de_rs2_i) begin
            fwd_b_o = 2'b01;
        end
        if (reset_i) begin
            fwd_a_o = 2'b00;
            fwd_b_o = 2'b00;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if ((w_mem_stall || w_load_use) && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redirect && r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (w_mem_stall) begin
                if (r_wait_cnt != WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + WW'(1);
                end
                if (r_wait_cnt >= WAIT_LAST) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign state_o       = r_state;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;
    assign mem_timeout_o = r_mem_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed control vectors, forwarding selects,
// counters (small CNT_W to reach saturation) and the memory timeout flag.
module tb_hazard_ctrl;

    localparam int CNT_W = 3;
    localparam int MEM_TIMEOUT = 4;

    // Control vector {pc,fd,de,em,mw enables, fd,de,mw flushes}
    localparam logic [7:0] C_RUN   = 8'hF8;
    localparam logic [7:0] C_RESET = 8'h07;
    localparam logic [7:0] C_MEM   = 8'h09;
    localparam logic [7:0] C_REDIR = 8'hFE;
    localparam logic [7:0] C_LOAD  = 8'h3A;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [4:0]       fd_rs1_i, fd_rs2_i, de_rs1_i, de_rs2_i, de_rd_i, em_rd_i, mw_rd_i;
    logic             fd_uses_rs1_i, fd_uses_rs2_i, de_mem_read_i;
    logic             em_reg_write_i, mw_reg_write_i, e_pc_select_i, dmem_req_i, dmem_ready_i;
    logic             pc_en_o, fd_en_o, de_en_o, em_en_o, mw_en_o;
    logic             fd_flush_o, de_flush_o, mw_flush_o;
    logic [1:0]       fwd_a_o, fwd_b_o, state_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
    logic             mem_timeout_o;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .fd_rs1_i(fd_rs1_i), .fd_rs2_i(fd_rs2_i),
        .fd_uses_rs1_i(fd_uses_rs1_i), .fd_uses_rs2_i(fd_uses_rs2_i),
        .de_rs1_i(de_rs1_i), .de_rs2_i(de_rs2_i), .de_rd_i(de_rd_i),
        .de_mem_read_i(de_mem_read_i),
        .em_rd_i(em_rd_i), .em_reg_write_i(em_reg_write_i),
        .mw_rd_i(mw_rd_i), .mw_reg_write_i(mw_reg_write_i),
        .e_pc_select_i(e_pc_select_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .pc_en_o(pc_en_o), .fd_en_o(fd_en_o), .de_en_o(de_en_o),
        .em_en_o(em_en_o), .mw_en_o(mw_en_o),
        .fd_flush_o(fd_flush_o), .de_flush_o(de_flush_o), .mw_flush_o(mw_flush_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .state_o(state_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
        .mem_timeout_o(mem_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=time_limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] ctrl();
        return {pc_en_o, fd_en_o, de_en_o, em_en_o, mw_en_o, fd_flush_o, de_flush_o, mw_flush_o};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        fd_rs1_i = 0; fd_rs2_i = 0; de_rs1_i = 0; de_rs2_i = 0; de_rd_i = 0;
        em_rd_i = 0; mw_rd_i = 0; fd_uses_rs1_i = 0; fd_uses_rs2_i = 0;
        de_mem_read_i = 0; em_reg_write_i = 0; mw_reg_write_i = 0;
        e_pc_select_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic [1:0] st,
                            input int stall, input int flush, input logic tmo);
        chk({tag, "_state"}, 16'(state_o), 16'(st));
        chk({tag, "_stall"}, 16'(stall_cnt_o), 16'(stall));
        chk({tag, "_flush"}, 16'(flush_cnt_o), 16'(flush));
        chk({tag, "_tmo"}, 16'(mem_timeout_o), 16'(tmo));
    endtask

    initial begin
        clear_inputs();
        reset_i = 1'b1;
        settle();
        chk("reset_ctrl", 16'(ctrl()), 16'(C_RESET));
        chk("reset_fwd", 16'({fwd_a_o, fwd_b_o}), 16'h0);
        chk_regs("reset", 2'd0, 0, 0, 1'b0);
        tick();
        tick();
        reset_i = 1'b0;
        settle();
        chk("idle_ctrl", 16'(ctrl()), 16'(C_RUN));

        // Load-use on rs1
        de_mem_read_i = 1; de_rd_i = 5; fd_rs1_i = 5; fd_uses_rs1_i = 1;
        settle();
        chk("lu_rs1_ctrl", 16'(ctrl()), 16'(C_LOAD));
        tick();
        chk_regs("lu_rs1", 2'd1, 1, 0, 1'b0);

        // Load-use on rs2 only
        fd_uses_rs1_i = 0; fd_uses_rs2_i = 1; fd_rs2_i = 5;
        settle();
        chk("lu_rs2_ctrl", 16'(ctrl()), 16'(C_LOAD));
        tick();
        chk_regs("lu_rs2", 2'd1, 2, 0, 1'b0);

        // x0 destination never stalls
        de_rd_i = 0; fd_rs1_i = 0; fd_rs2_i = 0; fd_uses_rs1_i = 1;
        settle();
        chk("lu_x0_ctrl", 16'(ctrl()), 16'(C_RUN));
        tick();
        chk_regs("lu_x0", 2'd0, 2, 0, 1'b0);

        // Match only on an unused source operand
        de_rd_i = 5; fd_rs1_i = 5; fd_rs2_i = 6; fd_uses_rs1_i = 0; fd_uses_rs2_i = 1;
        settle();
        chk("lu_unused_ctrl", 16'(ctrl()), 16'(C_RUN));
        tick();
        chk_regs("lu_unused", 2'd0, 2, 0, 1'b0);

        // Redirect beats a simultaneous load-use
        fd_uses_rs1_i = 1; e_pc_select_i = 1;
        settle();
        chk("redir_lu_ctrl", 16'(ctrl()), 16'(C_REDIR));
        tick();
        chk_regs("redir_lu", 2'd3, 2, 1, 1'b0);

        // Three memory wait cycles, redirect pending from the second one
        clear_inputs();
        dmem_req_i = 1;
        settle();
        chk("mw1_ctrl", 16'(ctrl()), 16'(C_MEM));
        tick();
        chk_regs("mw1", 2'd2, 3, 1, 1'b0);
        e_pc_select_i = 1;
        settle();
        chk("mw2_ctrl", 16'(ctrl()), 16'(C_MEM));
        tick();
        chk_regs("mw2", 2'd2, 4, 1, 1'b0);
        settle();
        chk("mw3_ctrl", 16'(ctrl()), 16'(C_MEM));
        tick();
        chk_regs("mw3", 2'd2, 5, 1, 1'b0);
        dmem_ready_i = 1;
        settle();
        chk("mw_done_ctrl", 16'(ctrl()), 16'(C_REDIR));
        tick();
        chk_regs("mw_done", 2'd3, 5, 2, 1'b0);

        // Forwarding priority and x0
        clear_inputs();
        em_rd_i = 7; mw_rd_i = 7; de_rs1_i = 7; em_reg_write_i = 1; mw_reg_write_i = 1;
        settle();
        chk("fwd_em", 16'({fwd_a_o, fwd_b_o}), 16'b1000);
        em_reg_write_i = 0;
        settle();
        chk("fwd_mw", 16'({fwd_a_o, fwd_b_o}), 16'b0100);
        mw_rd_i = 0; de_rs1_i = 0;
        settle();
        chk("fwd_x0", 16'({fwd_a_o, fwd_b_o}), 16'b0000);
        em_rd_i = 9; mw_rd_i = 9; de_rs2_i = 9; em_reg_write_i = 1; dmem_req_i = 1;
        settle();
        chk("fwd_b_em_stall", 16'({fwd_a_o, fwd_b_o}), 16'b0010);
        chk("fwd_b_stall_ctrl", 16'(ctrl()), 16'(C_MEM));
        em_reg_write_i = 0; dmem_req_i = 0;
        settle();
        chk("fwd_b_mw", 16'({fwd_a_o, fwd_b_o}), 16'b0001);

        // Timeout after four consecutive waits; stall counter saturates at 7
        clear_inputs();
        dmem_req_i = 1;
        tick();
        chk_regs("to1", 2'd2, 6, 2, 1'b0);
        tick();
        chk_regs("to2", 2'd2, 7, 2, 1'b0);
        tick();
        chk_regs("to3", 2'd2, 7, 2, 1'b0);
        tick();
        chk_regs("to4", 2'd2, 7, 2, 1'b1);
        dmem_ready_i = 1;
        settle();
        chk("to_ready_ctrl", 16'(ctrl()), 16'(C_RUN));
        tick();
        chk_regs("to_after", 2'd0, 7, 2, 1'b1);

        // Asynchronous reset in the middle of a wait
        dmem_ready_i = 0;
        tick();
        chk("pre_rst_state", 16'(state_o), 16'd2);
        reset_i = 1'b1;
        settle();
        chk_regs("async_rst", 2'd0, 0, 0, 1'b0);
        chk("async_rst_ctrl", 16'(ctrl()), 16'(C_RESET));
        tick();
        reset_i = 1'b0;
        settle();
        chk("post_rst_ctrl", 16'(ctrl()), 16'(C_MEM));
        // Wait counter must restart from zero: three waits leave the flag clear
        tick();
        tick();
        tick();
        chk_regs("post_rst_w3", 2'd2, 3, 0, 1'b0);
        tick();
        chk_regs("post_rst_w4", 2'd2, 4, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
